// File: rtl/queue_arb_pkg.sv
// Shared constants for the queue push arbiter: FSM state encoding and queue capacity helper.
package queue_arb_pkg;

    localparam logic [1:0] ST_ARB     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    function automatic int unsigned max_buf(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first set request
// found scanning from ptr_i upward, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic found_s;
    int   idx_s;

    // Priority scan starting at the round-robin pointer.
    always_comb begin
        grant_o = {NUM_REQ{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/queue_push_arbiter.sv
// Shares one circular queue push port among NUM_REQ producers with round-robin
// arbitration, a free-slot credit mirror and a flush/recover sequence.
module queue_push_arbiter
    import queue_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_IN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_IN,
    output logic [NUM_REQ-1:0]            grant_OUT,
    input  logic                          flushReq_IN,
    input  logic                          qPop_IN,
    input  logic                          qEmpty_IN,
    output logic                          qPush_OUT,
    output logic [DATA_WIDTH-1:0]         qData_OUT,
    output logic                          qFlush_OUT,
    output logic [ADDR_WIDTH:0]           credits_OUT,
    output logic                          busy_OUT
);

    localparam int                PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] CRED_MAX = (ADDR_WIDTH+1)'(max_buf(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] CRED_ONE = (ADDR_WIDTH+1)'(1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   credits_q, credits_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  q_push_q, q_push_d;
    logic [DATA_WIDTH-1:0] q_data_q, q_data_d;
    logic                  q_flush_q, q_flush_d;
    logic                  busy_q, busy_d;

    logic                  grant_en_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  grant_any_s;
    logic [PW-1:0]         win_idx_s;
    logic                  pop_s;

    // Reset gates the grant so nothing leaks out combinationally while held.
    assign grant_en_s  = reset && (state_q == ST_ARB) && !flushReq_IN
                         && (credits_q != {(ADDR_WIDTH+1){1'b0}});
    assign grant_any_s = |grant_s;
    assign pop_s       = qPop_IN && !qEmpty_IN;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .req_i   (req_IN & {NUM_REQ{grant_en_s}}),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s)
    );

    // Encode the one-hot winner back to an index for data select and pointer update.
    always_comb begin
        win_idx_s = {PW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                win_idx_s = PW'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // FSM next state and the flush/busy flags that follow it.
    always_comb begin
        case (state_q)
            ST_ARB:     state_d = flushReq_IN ? ST_FLUSH : ST_ARB;
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_ARB;
            default:    state_d = ST_ARB;
        endcase
        q_flush_d = (state_d == ST_FLUSH);
        busy_d    = (state_d != ST_ARB);
    end

    // Credit mirror: pops only count while arbitrating; a flush refills the queue view.
    always_comb begin
        credits_d = credits_q;
        if (state_q == ST_FLUSH) begin
            credits_d = CRED_MAX;
        end else if (state_q == ST_ARB) begin
            if (grant_any_s && !pop_s) begin
                credits_d = credits_q - CRED_ONE;
            end else if (pop_s && !grant_any_s && (credits_q != CRED_MAX)) begin
                credits_d = credits_q + CRED_ONE;
            end else begin
                credits_d = credits_q;
            end
        end else begin
            credits_d = credits_q;
        end
    end

    // Push register, held data and round-robin pointer advance.
    always_comb begin
        q_push_d = grant_any_s;
        if (grant_any_s) begin
            q_data_d = reqData_IN[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            if (int'(win_idx_s) == NUM_REQ - 1) begin
                rr_ptr_d = {PW{1'b0}};
            end else begin
                rr_ptr_d = win_idx_s + PW'(1);
            end
        end else begin
            q_data_d = q_data_q;
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; reset drops any in-flight push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ARB;
            credits_q <= CRED_MAX;
            rr_ptr_q  <= {PW{1'b0}};
            q_push_q  <= 1'b0;
            q_data_q  <= {DATA_WIDTH{1'b0}};
            q_flush_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            rr_ptr_q  <= rr_ptr_d;
            q_push_q  <= q_push_d;
            q_data_q  <= q_data_d;
            q_flush_q <= q_flush_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_OUT   = grant_s;
    assign qPush_OUT   = q_push_q;
    assign qData_OUT   = q_data_q;
    assign qFlush_OUT  = q_flush_q;
    assign credits_OUT = credits_q;
    assign busy_OUT    = busy_q;

endmodule
